// File: rtl/input_fifo.sv
// Router input buffer: circular flit FIFO with first-word-fall-through head,
// per-read credit return to the upstream link and sticky misuse flags.
`timescale 1ns/1ps
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module input_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [`DATA_WIDTH-1:0]    datain,
  input  logic                      validin,
  input  logic                      read_en,
  output logic [`DATA_WIDTH-1:0]    dataout,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      credit_out,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [`DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   credit_q, credit_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic                   wr_acc, rd_acc;

  // Acceptance is decided purely on registered occupancy, so a full FIFO
  // drops a same-cycle write and an empty FIFO ignores a same-cycle read.
  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign wr_acc = validin && !full;
  assign rd_acc = read_en && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    credit_d    = 1'b0;
    overflow_d  = overflow_q  || (validin && full);
    underflow_d = underflow_q || (read_en && empty);
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      credit_d = 1'b1;
    end
    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      credit_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      credit_q    <= credit_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not cleared on reset; the zeroed count hides stale entries.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= datain;
  end

  assign dataout    = empty ? '0 : mem_q[rd_ptr_q];
  assign count      = count_q;
  assign credit_out = credit_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_input_fifo.sv
// Self-checking bench for input_fifo: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_input_fifo;

  localparam int DEPTH = 4;
  localparam int W     = `DATA_WIDTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  datain;
  logic          validin;
  logic          read_en;
  logic [W-1:0]  dataout;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          credit_out;
  logic          overflow;
  logic          underflow;

  input_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .datain(datain), .validin(validin),
    .read_en(read_en), .dataout(dataout), .empty(empty), .full(full),
    .count(count), .credit_out(credit_out), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model state
  logic [W-1:0] mq[$];
  bit           m_ovf, m_udf, m_credit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit v, input logic [W-1:0] d, input bit r, input bit rs);
    bit was_full, was_empty;
    if (rs) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_credit = 0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      m_credit  = r && !was_empty;
      if (r && !was_empty) void'(mq.pop_front());
      if (v && !was_full)  mq.push_back(d);
      if (v && was_full)  m_ovf = 1;
      if (r && was_empty) m_udf = 1;
    end
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] exp_d;
    exp_d = (mq.size() != 0) ? mq[0] : '0;
    chk({tag, ".count"},     32'(count),      32'(mq.size()));
    chk({tag, ".empty"},     32'(empty),      32'(mq.size() == 0));
    chk({tag, ".full"},      32'(full),       32'(mq.size() == DEPTH));
    chk({tag, ".dataout"},   32'(dataout),    32'(exp_d));
    chk({tag, ".credit"},    32'(credit_out), 32'(m_credit));
    chk({tag, ".overflow"},  32'(overflow),   32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow),  32'(m_udf));
  endtask

  // Drive one cycle, advance the model at the edge, sample #1 later.
  task automatic step(input bit v, input logic [W-1:0] d, input bit r, input bit rs,
                      input bit cmp, input string tag);
    validin = v; datain = d; read_en = r; rst = rs;
    @(posedge clk);
    model_edge(v, d, r, rs);
    #1;
    if (cmp) check_model(tag);
  endtask

  typedef struct {
    bit           v;
    logic [W-1:0] d;
    bit           r;
    bit           rs;
    int unsigned  e_cnt;
    logic [W-1:0] e_dout;
    bit           e_cr;
    bit           e_ovf;
    bit           e_udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit v, logic [W-1:0] d, bit r, bit rs, int unsigned c,
                              logic [W-1:0] o, bit cr, bit ov, bit ud);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.rs = rs; t.e_cnt = c; t.e_dout = o;
    t.e_cr = cr; t.e_ovf = ov; t.e_udf = ud;
    return t;
  endfunction

  initial begin
    int unsigned credits;
    validin = 0; read_en = 0; datain = '0; rst = 1;

    // Reset state
    step(0, '0, 0, 1, 0, "rst");
    step(0, '0, 0, 1, 1, "rst");

    // Fill/drain, then full+simultaneous, then reset
    vecs.push_back(mk(1, 8'hA1, 0, 0, 1, 8'hA1, 0, 0, 0));
    vecs.push_back(mk(1, 8'hA2, 0, 0, 2, 8'hA1, 0, 0, 0));
    vecs.push_back(mk(1, 8'hA3, 0, 0, 3, 8'hA1, 0, 0, 0));
    vecs.push_back(mk(1, 8'hA4, 0, 0, 4, 8'hA1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 3, 8'hA2, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 2, 8'hA3, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'hA4, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 8'hA1, 0, 0, 1, 8'hA1, 0, 0, 0));
    vecs.push_back(mk(1, 8'hA2, 0, 0, 2, 8'hA1, 0, 0, 0));
    vecs.push_back(mk(1, 8'hA3, 0, 0, 3, 8'hA1, 0, 0, 0));
    vecs.push_back(mk(1, 8'hA4, 0, 0, 4, 8'hA1, 0, 0, 0));
    vecs.push_back(mk(1, 8'hC5, 1, 0, 3, 8'hA2, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 2, 8'hA3, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'hA4, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0));
    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].rs, 0, "tbl");
      chk($sformatf("tbl%0d.count", i),   32'(count),      32'(vecs[i].e_cnt));
      chk($sformatf("tbl%0d.empty", i),   32'(empty),      32'(vecs[i].e_cnt == 0));
      chk($sformatf("tbl%0d.full", i),    32'(full),       32'(vecs[i].e_cnt == DEPTH));
      chk($sformatf("tbl%0d.dataout", i), 32'(dataout),    32'(vecs[i].e_dout));
      chk($sformatf("tbl%0d.credit", i),  32'(credit_out), 32'(vecs[i].e_cr));
      chk($sformatf("tbl%0d.ovf", i),     32'(overflow),   32'(vecs[i].e_ovf));
      chk($sformatf("tbl%0d.udf", i),     32'(underflow),  32'(vecs[i].e_udf));
    end

    // Pointer wrap: write 3, read 3, write B1..B4, read 4
    for (int i = 0; i < 3; i++) step(1, W'(8'h90 + i), 0, 0, 1, "wrap.w");
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 1, "wrap.r");
    for (int i = 0; i < 4; i++) step(1, W'(8'hB1 + i), 0, 0, 1, "wrapB.w");
    chk("wrap.full", 32'(full), 32'(1));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap.head%0d", i), 32'(dataout), 32'(8'hB1 + i));
      step(0, '0, 1, 0, 1, "wrapB.r");
    end
    chk("wrap.ovf", 32'(overflow), 32'(0));
    chk("wrap.udf", 32'(underflow), 32'(0));

    // Empty + simultaneous write/read
    step(0, '0, 0, 1, 1, "rst2");
    step(1, 8'hD1, 1, 0, 1, "emptysim");
    chk("emptysim.count", 32'(count), 32'(1));
    chk("emptysim.dout", 32'(dataout), 32'(8'hD1));
    chk("emptysim.udf", 32'(underflow), 32'(1));
    chk("emptysim.credit", 32'(credit_out), 32'(0));

    // Reset mid-stream with traffic asserted
    step(0, '0, 0, 1, 1, "rst3");
    step(1, 8'h11, 0, 0, 1, "mid.w");
    step(1, 8'h12, 0, 0, 1, "mid.w");
    step(1, 8'h13, 1, 1, 1, "mid.rst");
    chk("mid.count", 32'(count), 32'(0));
    chk("mid.empty", 32'(empty), 32'(1));
    chk("mid.dout", 32'(dataout), 32'(0));
    chk("mid.credit", 32'(credit_out), 32'(0));
    chk("mid.flags", 32'({overflow, underflow}), 32'(0));

    // Streaming at occupancy 1
    step(1, 8'hE0, 0, 0, 1, "stream.prime");
    credits = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, W'(8'hE1 + i), 1, 0, 1, "stream");
      chk($sformatf("stream%0d.dout", i), 32'(dataout), 32'(8'hE1 + i));
      chk($sformatf("stream%0d.count", i), 32'(count), 32'(1));
      if (credit_out === 1'b1) credits++;
    end
    chk("stream.credits", credits, 20);

    // Randomized traffic
    step(0, '0, 0, 1, 1, "rst4");
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) < 55), W'($urandom), ($urandom_range(99) < 50),
           ($urandom_range(99) < 2), 1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/input_fifo.md
INPUT_FIFO -- requirements
Module: input_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, flit storage entries (power of two, >=2).
REQ-002 SHALL use `DATA_WIDTH from parameters.v as flit width; no local width parameter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port datain  input  `DATA_WIDTH  flit from upstream link (neighbour crossbar dataout).
REQ-006 SHALL have port validin  input  1  datain valid this cycle (neighbour crossbar validout).
REQ-007 SHALL have port read_en  input  1  dequeue request from local arbiter/crossbar grant.
REQ-008 SHALL have port dataout  output  `DATA_WIDTH  head flit presented to crossbar.
REQ-009 SHALL have port empty  output  1  no flit stored.
REQ-010 SHALL have port full  output  1  DEPTH flits stored.
REQ-011 SHALL have port count  output  log2(DEPTH)+1  stored flit count.
REQ-012 SHALL have port credit_out  output  1  one-cycle pulse returning one buffer credit upstream.
REQ-013 SHALL have port overflow  output  1  sticky: write attempted while full.
REQ-014 SHALL have port underflow  output  1  sticky: read attempted while empty.

Function
REQ-015 SHALL store flits in circular buffer with write pointer, read pointer, occupancy counter.
REQ-016 SHALL accept a write (store datain at wr_ptr, wr_ptr+1 mod DEPTH) when validin=1 and full=0 at the edge.
REQ-017 SHALL accept a read (rd_ptr+1 mod DEPTH) when read_en=1 and empty=0 at the edge.
REQ-018 SHALL present dataout first-word-fall-through: buffer[rd_ptr] when empty=0, all-zero when empty=1.
REQ-019 SHALL derive empty=(count==0), full=(count==DEPTH) from registered count; no combinational path from validin/read_en to empty/full.
REQ-020 SHALL update count: +1 write only, -1 read only, unchanged on both or neither.
REQ-021 SHALL wrap pointers DEPTH-1 -> 0 without loss or duplication.
REQ-022 Full + validin=1 + read_en=1: read accepted, write dropped (full decided on pre-edge state), overflow set.
REQ-023 Empty + validin=1 + read_en=1: write accepted, read ignored (no same-cycle bypass), underflow set, count becomes 1.
REQ-024 Write-only while full: flit dropped, storage/pointers unchanged, overflow set.
REQ-025 Read-only while empty: pointers unchanged, underflow set.
REQ-026 SHALL assert credit_out for exactly one cycle, the cycle after each accepted read; back-to-back reads give consecutive pulses.
REQ-027 overflow and underflow SHALL stay set until rst.
REQ-028 Latency: flit written at edge N visible on dataout after edge N when it is the only entry.

Reset
REQ-029 rst=1 at an edge SHALL clear wr_ptr, rd_ptr, count to 0; empty=1, full=0, dataout=0, credit_out=0, overflow=0, underflow=0.
REQ-030 rst SHALL override simultaneous validin/read_en: no write, no read, no credit pulse on the following cycle.
REQ-031 Reset mid-operation SHALL discard stored flits; storage array contents need not be cleared.

Verification
REQ-032 Fill/drain: DEPTH=4, write 0xA1..0xA4 -> full=1, count=4; then read 4 -> dataout sequence A1,A2,A3,A4, four credit_out pulses each one cycle after its read, empty=1.
REQ-033 Wrap: write 3, read 3, write 4 (0xB1..0xB4), read 4 -> order B1..B4 intact, no overflow/underflow.
REQ-034 Full + simultaneous: full with A1..A4, validin=1 datain=0xC5, read_en=1 -> A1 removed, count=3, C5 not stored, overflow=1.
REQ-035 Empty + simultaneous: empty, validin=1 datain=0xD1, read_en=1 -> count=1, dataout=0xD1 next cycle, underflow=1, no credit_out.
REQ-036 Reset mid-stream: 2 flits stored, rst=1 with validin=1, read_en=1 -> next cycle count=0, empty=1, dataout=0, credit_out=0, flags 0.
REQ-037 Streaming: validin=1 and read_en=1 every cycle from count=1 for 20 cycles -> count stays 1, in-order delivery, 20 credit pulses.
